// File: rtl/light_monitor.sv
// light_monitor
// Watches the lamp drives of a two-direction traffic controller and latches
// the first illegal condition seen. Each posedge samples the lamps and the
// left-turn permit; fault outputs update at that same edge.
//
// Optional feature: define LIGHT_MONITOR_FLASH_EN to build the fault flasher
// (flash toggles every FLASH_DIV cycles while in FAULT). Without it, flash is
// tied low and no flash counter exists.
//
// Ports
//   clk                  system clock
//   reset                synchronous, active-high reset
//   LSNG, LSNY, LSNR     south-north green/yellow/red lamp drives
//   LEWG, LEWY, LEWR     east-west green/yellow/red lamp drives
//   left                 left-turn permit, active-low
//   fault_clr            one-cycle pulse, clears a latched fault
//   fault                latched fault flag
//   fault_code[2:0]      cause of the latched fault (0 = none)
//   sn_phase, ew_phase   tracked phase: 0 INIT, 1 RED, 2 GREEN, 3 YELLOW
//   flash                fault-indication flash drive
//
// state | meaning
// SYNC  | waiting for an all-red sample, no checks
// RUN   | checking every sample against the tracked phases
// FAULT | fault latched, lamps ignored until fault_clr
module light_monitor #(
    parameter int MIN_Y     = 3,
    parameter int FLASH_DIV = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       LSNG,
    input  logic       LSNY,
    input  logic       LSNR,
    input  logic       LEWG,
    input  logic       LEWY,
    input  logic       LEWR,
    input  logic       left,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] sn_phase,
    output logic [1:0] ew_phase,
    output logic       flash
);

    typedef enum logic [1:0] {ST_SYNC, ST_RUN, ST_FAULT} state_t;

    localparam logic [1:0] PH_INIT   = 2'd0;
    localparam logic [1:0] PH_RED    = 2'd1;
    localparam logic [1:0] PH_GREEN  = 2'd2;
    localparam logic [1:0] PH_YELLOW = 2'd3;
    localparam logic [5:0] MIN_Y_W   = 6'(MIN_Y);

    state_t     state, state_nxt;
    logic [1:0] sn_nxt, ew_nxt;
    logic [5:0] sn_ytmr, ew_ytmr, sn_ytmr_nxt, ew_ytmr_nxt;
    logic       fault_nxt;
    logic [2:0] code_nxt, code_now;

    logic       sn_valid, ew_valid;
    logic [1:0] sn_samp, ew_samp;
    logic       all_red;

    // Invalid samples decode to INIT; callers gate on the valid flag.
    function automatic logic [1:0] decode(input logic g, input logic y, input logic r);
        case ({g, y, r})
            3'b100:  return PH_GREEN;
            3'b010:  return PH_YELLOW;
            3'b001:  return PH_RED;
            default: return PH_INIT;
        endcase
    endfunction

    function automatic logic legal_move(input logic [1:0] from, input logic [1:0] to);
        return (to == from) ||
               (from == PH_RED    && to == PH_GREEN)  ||
               (from == PH_GREEN  && to == PH_YELLOW) ||
               (from == PH_YELLOW && to == PH_RED);
    endfunction

    function automatic logic [5:0] step_timer(input logic [1:0] from, input logic [1:0] to,
                                              input logic [5:0] t);
        if (to != PH_YELLOW)    return 6'd0;
        if (from != PH_YELLOW)  return 6'd1;
        if (t == 6'd63)         return t;
        return t + 6'd1;
    endfunction

    always_comb begin
        sn_samp  = decode(LSNG, LSNY, LSNR);
        ew_samp  = decode(LEWG, LEWY, LEWR);
        sn_valid = (sn_samp != PH_INIT);
        ew_valid = (ew_samp != PH_INIT);
        all_red  = (sn_samp == PH_RED) && (ew_samp == PH_RED);

        // Lowest code wins when several conditions coincide.
        code_now = 3'd0;
        if ((LSNG | LSNY) && (LEWG | LEWY))
            code_now = 3'd1;
        else if (!sn_valid || !ew_valid)
            code_now = 3'd2;
        else if (!legal_move(sn_phase, sn_samp))
            code_now = 3'd3;
        else if (!legal_move(ew_phase, ew_samp))
            code_now = 3'd4;
        else if ((sn_phase == PH_YELLOW && sn_samp == PH_RED && sn_ytmr < MIN_Y_W) ||
                 (ew_phase == PH_YELLOW && ew_samp == PH_RED && ew_ytmr < MIN_Y_W))
            code_now = 3'd5;
        else if (!left && (LSNG || LEWG))
            code_now = 3'd6;
    end

    always_comb begin
        state_nxt   = state;
        sn_nxt      = sn_phase;
        ew_nxt      = ew_phase;
        sn_ytmr_nxt = sn_ytmr;
        ew_ytmr_nxt = ew_ytmr;
        fault_nxt   = fault;
        code_nxt    = fault_code;
        case (state)
            ST_SYNC: begin
                if (all_red) begin
                    state_nxt   = ST_RUN;
                    sn_nxt      = PH_RED;
                    ew_nxt      = PH_RED;
                    sn_ytmr_nxt = 6'd0;
                    ew_ytmr_nxt = 6'd0;
                end
            end
            ST_RUN: begin
                if (code_now != 3'd0) begin
                    // Phases and timers keep their last legal values.
                    state_nxt = ST_FAULT;
                    fault_nxt = 1'b1;
                    code_nxt  = code_now;
                end else begin
                    sn_nxt      = sn_samp;
                    ew_nxt      = ew_samp;
                    sn_ytmr_nxt = step_timer(sn_phase, sn_samp, sn_ytmr);
                    ew_ytmr_nxt = step_timer(ew_phase, ew_samp, ew_ytmr);
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_nxt   = ST_SYNC;
                    fault_nxt   = 1'b0;
                    code_nxt    = 3'd0;
                    sn_nxt      = PH_INIT;
                    ew_nxt      = PH_INIT;
                    sn_ytmr_nxt = 6'd0;
                    ew_ytmr_nxt = 6'd0;
                end
            end
            default: state_nxt = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_SYNC;
            sn_phase   <= PH_INIT;
            ew_phase   <= PH_INIT;
            sn_ytmr    <= 6'd0;
            ew_ytmr    <= 6'd0;
            fault      <= 1'b0;
            fault_code <= 3'd0;
        end else begin
            state      <= state_nxt;
            sn_phase   <= sn_nxt;
            ew_phase   <= ew_nxt;
            sn_ytmr    <= sn_ytmr_nxt;
            ew_ytmr    <= ew_ytmr_nxt;
            fault      <= fault_nxt;
            fault_code <= code_nxt;
        end
    end

`ifdef LIGHT_MONITOR_FLASH_EN
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    // Down-counter reloads with FLASH_DIV-1; flash toggles on terminal count.
    logic [FW-1:0] flash_cnt;

    always_ff @(posedge clk) begin
        if (reset || state_nxt != ST_FAULT) begin
            flash     <= 1'b0;
            flash_cnt <= '0;
        end else if (state != ST_FAULT) begin
            flash     <= 1'b0;
            flash_cnt <= FW'(FLASH_DIV - 1);
        end else if (flash_cnt == '0) begin
            flash     <= ~flash;
            flash_cnt <= FW'(FLASH_DIV - 1);
        end else begin
            flash_cnt <= flash_cnt - 1'b1;
        end
    end
`else
    // Flash is permanently low in this build; the term is always false.
    assign flash = 1'b0 & (FLASH_DIV == 0);
`endif

endmodule

// File: tb/tb_light_monitor.sv
module tb_light_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       LSNG = 0, LSNY = 0, LSNR = 0, LEWG = 0, LEWY = 0, LEWR = 0;
    logic       left = 1'b1;
    logic       fault_clr = 1'b0;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] sn_phase, ew_phase;
    logic       flash;

    int checks = 0;
    int errors = 0;

    light_monitor #(.MIN_Y(3), .FLASH_DIV(4)) dut (
        .clk(clk), .reset(reset),
        .LSNG(LSNG), .LSNY(LSNY), .LSNR(LSNR),
        .LEWG(LEWG), .LEWY(LEWY), .LEWR(LEWR),
        .left(left), .fault_clr(fault_clr),
        .fault(fault), .fault_code(fault_code),
        .sn_phase(sn_phase), .ew_phase(ew_phase), .flash(flash)
    );

    always #5 clk = ~clk;

    // Lamp encodings {SN G,Y,R, EW G,Y,R}
    localparam logic [5:0] RR  = 6'b001_001;
    localparam logic [5:0] GR  = 6'b100_001;
    localparam logic [5:0] YR  = 6'b010_001;
    localparam logic [5:0] RG  = 6'b001_100;
    localparam logic [5:0] RY  = 6'b001_010;
    localparam logic [5:0] GG  = 6'b100_100;
    localparam logic [5:0] RGY = 6'b001_110;
    localparam logic [5:0] GY  = 6'b100_010;
    localparam logic [5:0] OFF = 6'b000_000;

    typedef struct {
        logic [5:0] lamps;
        logic       lft;
        logic       clr;
        logic       rst;
        logic       f;
        logic [2:0] c;
        logic [1:0] sn;
        logic [1:0] ew;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [5:0] l, input logic lf, input logic cl, input logic rs,
                       input logic f, input logic [2:0] c, input logic [1:0] sn,
                       input logic [1:0] ew);
        vec_t v;
        v.lamps = l; v.lft = lf; v.clr = cl; v.rst = rs;
        v.f = f; v.c = c; v.sn = sn; v.ew = ew;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    // Drive one sample, let the edge take it, then look 1 time unit later.
    task automatic apply(input logic [5:0] l, input logic lf, input logic cl, input logic rs);
        {LSNG, LSNY, LSNR, LEWG, LEWY, LEWR} = l;
        left = lf; fault_clr = cl; reset = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //  lamps lf clr rst | fault code sn ew
        add(RR,  1, 0, 1,  0, 0, 0, 0);   // reset state
        add(RR,  1, 0, 0,  0, 0, 1, 1);   // sync -> run
        for (int i = 0; i < 5; i++) add(GR, 1, 0, 0, 0, 0, 2, 1);
        for (int i = 0; i < 3; i++) add(YR, 1, 0, 0, 0, 0, 3, 1);
        add(RR,  1, 0, 0,  0, 0, 1, 1);   // yellow of exactly MIN_Y is fine
        add(RG,  1, 0, 0,  0, 0, 1, 2);
        add(RY,  1, 0, 0,  0, 0, 1, 3);
        add(RY,  1, 0, 0,  0, 0, 1, 3);
        add(RR,  1, 0, 0,  1, 5, 1, 3);   // short yellow, phases frozen
        add(GG,  1, 0, 0,  1, 5, 1, 3);   // later fault does not overwrite
        add(RR,  1, 1, 0,  0, 0, 0, 0);   // clear -> SYNC
        add(GR,  1, 0, 0,  0, 0, 0, 0);   // SYNC ignores non-all-red
        add(RR,  1, 0, 0,  0, 0, 1, 1);
        add(GG,  1, 0, 0,  1, 1, 1, 1);   // conflict
        add(RR,  1, 1, 0,  0, 0, 0, 0);
        add(RR,  1, 1, 0,  0, 0, 1, 1);   // clr in SYNC has no effect
        add(GR,  1, 0, 0,  0, 0, 2, 1);
        add(RR,  1, 0, 0,  1, 3, 2, 1);   // green -> red directly
        add(RR,  1, 1, 0,  0, 0, 0, 0);
        add(RR,  1, 0, 0,  0, 0, 1, 1);
        add(RGY, 1, 0, 0,  1, 2, 1, 1);   // EW two lamps lit
        add(RR,  1, 1, 0,  0, 0, 0, 0);
        add(RR,  0, 0, 0,  0, 0, 1, 1);   // left=0 with all red is fine
        add(GR,  0, 0, 0,  1, 6, 1, 1);   // left=0 with SN green
        add(RR,  1, 1, 1,  0, 0, 0, 0);   // reset and clear together
        add(RR,  1, 0, 0,  0, 0, 1, 1);
        add(RY,  1, 0, 0,  1, 4, 1, 1);   // EW red -> yellow
        add(GR,  1, 0, 1,  0, 0, 0, 0);   // reset mid-FAULT
        add(GR,  1, 0, 0,  0, 0, 0, 0);   // history gone, still SYNC
        add(OFF, 1, 0, 0,  0, 0, 0, 0);
        add(RR,  1, 0, 0,  0, 0, 1, 1);
        add(OFF, 1, 0, 0,  1, 2, 1, 1);   // no lamps lit
        add(RR,  1, 0, 1,  0, 0, 0, 0);
        add(RR,  1, 0, 0,  0, 0, 1, 1);
        add(GY,  0, 0, 0,  1, 1, 1, 1);   // conflict + illegal + left: lowest wins
        add(RR,  1, 0, 1,  0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].lamps, vecs[i].lft, vecs[i].clr, vecs[i].rst);
            chk("fault",      i, 8'(fault),      8'(vecs[i].f));
            chk("fault_code", i, 8'(fault_code), 8'(vecs[i].c));
            chk("sn_phase",   i, 8'(sn_phase),   8'(vecs[i].sn));
            chk("ew_phase",   i, 8'(ew_phase),   8'(vecs[i].ew));
            chk("flash",      i, 8'(flash),      8'(0));
        end

        // Long yellow saturates the timer instead of wrapping below MIN_Y.
        apply(RR, 1, 0, 0);
        apply(GR, 1, 0, 0);
        for (int i = 0; i < 70; i++) apply(YR, 1, 0, 0);
        chk("long_yellow_phase", 100, 8'(sn_phase), 8'(3));
        apply(RR, 1, 0, 0);
        chk("long_yellow_fault", 101, 8'(fault), 8'(0));
        chk("long_yellow_sn",    102, 8'(sn_phase), 8'(1));

        // Flash behaviour through a fault and a reset mid-FAULT.
        apply(RR, 1, 0, 1);
        apply(RR, 1, 0, 0);
        apply(GG, 1, 0, 0);
        chk("flash_entry_fault", 200, 8'(fault), 8'(1));
        chk("flash_entry",       201, 8'(flash), 8'(0));
        for (int k = 1; k <= 9; k++) begin
            logic exp_fl;
`ifdef LIGHT_MONITOR_FLASH_EN
            exp_fl = ((k / 4) % 2) == 1;
`else
            exp_fl = 1'b0;
`endif
            apply(GG, 1, 0, 0);
            chk("flash_run", 201 + k, 8'(flash), 8'(exp_fl));
        end
        apply(GG, 1, 0, 1);
        chk("flash_reset", 220, 8'(flash), 8'(0));
        chk("fault_reset", 221, 8'(fault), 8'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/light_monitor.md
LIGHT_MONITOR -- requirements
Module: light_monitor

Interface
REQ-001 Parameter MIN_Y, default 3: minimum legal yellow duration in clk cycles (1..63).
REQ-002 Parameter FLASH_DIV, default 25000000: flash half-period in clk cycles (used only with FLASH_EN).
REQ-003 clk  input  1  single system clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 LSNG, LSNY, LSNR  input  1 each  south-north green/yellow/red lamp drives from the controller.
REQ-006 LEWG, LEWY, LEWR  input  1 each  east-west green/yellow/red lamp drives.
REQ-007 left  input  1  left-turn permit, active-low (0 = left-turn phase).
REQ-008 fault_clr  input  1  one-cycle pulse that clears a latched fault.
REQ-009 fault  output  1  latched fault flag.
REQ-010 fault_code  output  3  cause of the latched fault (0 = none).
REQ-011 sn_phase, ew_phase  output  2 each  tracked phase per direction: 0 INIT, 1 RED, 2 GREEN, 3 YELLOW.
REQ-012 flash  output  1  fault-indication flash drive.

Function
REQ-013 Each posedge samples all lamp inputs and left; all checks use the sampled values and the previous tracked phase; outputs update at the same edge, so latency from an input change to a fault output is 1 cycle.
REQ-014 Top-level FSM states: SYNC, RUN, FAULT.
REQ-015 SYNC: no checks. Go to RUN when a sample shows SN = red-only and EW = red-only. Both phases are then set to RED.
REQ-016 RUN, per direction, legal phase moves: RED->GREEN, GREEN->YELLOW, YELLOW->RED, or hold. Any other move is an illegal sequence.
REQ-017 A direction's sample is invalid if it has zero lamps lit or more than one lamp lit.
REQ-018 Fault codes, checked in RUN:
  - 1: both directions non-red (conflict).
  - 2: invalid lamp sample.
  - 3: SN illegal sequence.
  - 4: EW illegal sequence.
  - 5: short yellow.
  - 6: left=0 while either direction is green.
REQ-019 When several conditions occur in the same sample, the lowest code number is latched.
REQ-020 Yellow timer per direction (6 bits):
  - Set to 1 on entry to YELLOW.
  - Increments on each further YELLOW sample, saturating at 63.
  - On YELLOW->RED, a timer value below MIN_Y raises code 5.
REQ-021 On any fault: FSM enters FAULT, fault=1, fault_code is latched, and phases freeze at their last legal values.
REQ-022 FAULT: ignores lamp inputs. A later fault condition does not overwrite fault_code.
REQ-023 fault_clr in FAULT: at that edge, fault=0, fault_code=0, phases=INIT, yellow timers=0, and the FSM goes to SYNC.
REQ-024 fault_clr in SYNC or RUN has no effect.
REQ-025 If fault_clr and reset are asserted together, reset wins. Results are the same either way.

Reset
REQ-026 reset forces, at that edge:
  - FSM=SYNC, fault=0, fault_code=0.
  - sn_phase=ew_phase=0, yellow timers=0.
  - flash=0, flash counter=0.
REQ-027 reset asserted mid-RUN or mid-FAULT discards all history. Checking resumes only after a fresh all-red sample.

Configuration
REQ-028 Macro LIGHT_MONITOR_FLASH_EN, when defined: while in FAULT, flash toggles every FLASH_DIV cycles, starting at 0 on FAULT entry; outside FAULT it is held at 0.
REQ-029 Without LIGHT_MONITOR_FLASH_EN: flash is constant 0 and no flash counter is synthesized.
REQ-030 All other behaviour is identical with and without LIGHT_MONITOR_FLASH_EN.

Verification
REQ-031 reset, then all-red for 1 cycle, then SN G(5 cycles) -> Y(3) -> R with EW red and left=1 -> fault=0 throughout; sn_phase follows 1,2,3,1.
REQ-032 In RUN, LSNG=1 and LEWG=1 in the same cycle -> next cycle fault=1, fault_code=1; a fault_clr pulse -> fault=0, FSM in SYNC.
REQ-033 MIN_Y=3, EW yellow for 2 cycles then red -> fault_code=5; a yellow of exactly 3 cycles -> no fault.
REQ-034 SN GREEN->RED directly -> fault_code=3. A sample with both LEWG=1 and LEWY=1 and SN conflict-free -> fault_code=2.
REQ-035 SN green with left=0 -> fault_code=6; after clear, an all-red sample with left=0 -> no fault.
REQ-036 With LIGHT_MONITOR_FLASH_EN and FLASH_DIV=4, force a fault -> flash toggles every 4 cycles; reset mid-FAULT -> flash=0 and fault=0 at the reset edge.
